// File: rtl/alu_muldiv.sv
// Iterative multiply/divide unit producing HI/LO: one bit per cycle in CALC,
// then a single FIX cycle applies sign correction and publishes the result.
module alu_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] busA,
  input  logic [WIDTH-1:0] busB,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opb;
  logic               is_div;
  logic               neg_q;
  logic               neg_r;
  logic               div_zero;

  logic               is_signed;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   div_diff;
  logic [2*WIDTH-1:0] div_next;

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign busy = (state != IDLE);

  // MULT and DIV (op[0]==0) work on magnitudes; signs are restored in FIX.
  assign is_signed = ~op[0];
  assign abs_a = (is_signed && busA[WIDTH-1]) ? -busA : busA;
  assign abs_b = (is_signed && busB[WIDTH-1]) ? -busB : busB;

  // Shift-add: multiplier sits in the low half and is consumed LSB first.
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};

  // Restoring divide: {remainder, quotient/dividend} shifts left each step.
  assign div_shift = acc[2*WIDTH-1:WIDTH-1];
  assign div_ge    = (div_shift >= {1'b0, opb});
  assign div_diff  = div_shift[WIDTH-1:0] - opb;
  assign div_next  = div_ge ? {div_diff, acc[WIDTH-2:0], 1'b1}
                            : {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};

  assign prod_fix = neg_q ? -acc : acc;
  assign quot_fix = div_zero ? '1 : (neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
  assign rem_fix  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      acc      <= '0;
      opb      <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !cancel) begin
            case (op)
              3'b000, 3'b001, 3'b010, 3'b011: begin
                state    <= CALC;
                cnt      <= '0;
                is_div   <= op[1];
                opb      <= op[1] ? abs_b : abs_a;
                acc      <= op[1] ? {{WIDTH{1'b0}}, abs_a} : {{WIDTH{1'b0}}, abs_b};
                neg_q    <= is_signed & (busA[WIDTH-1] ^ busB[WIDTH-1]);
                neg_r    <= is_signed & busA[WIDTH-1];
                div_zero <= op[1] & (busB == '0);
              end
              3'b100:  hi <= busA;
              3'b101:  lo <= busA;
              default: ;
            endcase
          end
        end
        CALC: begin
          if (cancel) begin
            state <= IDLE;
          end else begin
            acc <= is_div ? div_next : mul_next;
            cnt <= cnt + 1'b1;
            if (cnt == LAST) state <= FIX;
          end
        end
        FIX: begin
          state <= IDLE;
          if (!cancel) begin
            done <= 1'b1;
            if (is_div) begin
              hi <= rem_fix;
              lo <= quot_fix;
            end else begin
              {hi, lo} <= prod_fix;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed bench for alu_muldiv (WIDTH=32): results, latency, cancel, start-while-busy, reset.
module tb_alu_muldiv;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   op = 3'b000;
  logic [W-1:0] busA = '0;
  logic [W-1:0] busB = '0;
  logic         cancel = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int checks = 0;
  int errors = 0;

  localparam logic [2:0] MULT = 3'b000, MULTU = 3'b001, DIV = 3'b010,
                         DIVU = 3'b011, MTHI = 3'b100, MTLO = 3'b101;

  alu_muldiv #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .busA(busA), .busB(busB),
    .cancel(cancel), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge: drives start for one edge, then scrambles operands.
  task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1; op = o; busA = a; busB = b;
    @(negedge clk);
    start = 1'b0; op = 3'($urandom_range(0, 7)); busA = $urandom; busB = $urandom;
  endtask

  // Waits (bounded) for done after an accepted start; checks latency and HI/LO.
  task automatic wait_done(input string tag, input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
    int n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, " latency"}, 64'(n), 64'd33);
    $display("%s: hi=0x%08h lo=0x%08h edges=%0d", tag, hi, lo, n);
    check({tag, " hi"}, 64'(hi), 64'(exp_hi));
    check({tag, " lo"}, 64'(lo), 64'(exp_lo));
    check({tag, " busy at done"}, 64'(busy), 64'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset hi", 64'(hi), 64'd0);
    check("reset lo", 64'(lo), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(MULT, 32'hFFFFFFFE, 32'd3);
    check("MULT busy", 64'(busy), 64'd1);
    wait_done("MULT -2*3", 32'hFFFFFFFF, 32'hFFFFFFFA);
    @(negedge clk);
    check("done one cycle", 64'(done), 64'd0);

    issue(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done("MULTU max*max", 32'hFFFFFFFE, 32'h00000001);

    // Back-to-back: start issued in the done cycle is accepted.
    issue(DIV, 32'hFFFFFFF9, 32'd2);
    check("b2b busy", 64'(busy), 64'd1);
    wait_done("DIV -7/2", 32'hFFFFFFFF, 32'hFFFFFFFD);
    @(negedge clk);
    issue(DIVU, 32'd7, 32'd2);
    wait_done("DIVU 7/2", 32'd1, 32'd3);
    @(negedge clk);
    issue(DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_done("DIV MIN/-1", 32'd0, 32'h80000000);
    @(negedge clk);
    issue(MULT, 32'h80000000, 32'h80000000);
    wait_done("MULT MIN*MIN", 32'h40000000, 32'd0);
    @(negedge clk);
    issue(DIVU, 32'h1234, 32'd0);
    wait_done("DIVU x/0", 32'h1234, 32'hFFFFFFFF);
    @(negedge clk);
    issue(DIV, 32'hFFFFFFF9, 32'd0);
    wait_done("DIV -7/0", 32'hFFFFFFF9, 32'hFFFFFFFF);

    // Cancel at edge 10: state returns to IDLE, no done, HI/LO keep prior values.
    @(negedge clk);
    issue(MULT, 32'd1000, 32'd1000);
    repeat (8) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    check("cancel busy", 64'(busy), 64'd0);
    begin
      int seen = 0;
      repeat (40) begin
        @(negedge clk);
        if (done) seen++;
      end
      check("cancel no done", 64'(seen), 64'd0);
    end
    check("cancel hi kept", 64'(hi), 64'h00000000FFFFFFF9);
    check("cancel lo kept", 64'(lo), 64'h00000000FFFFFFFF);
    $display("cancel: busy=%0d hi=0x%08h lo=0x%08h", busy, hi, lo);

    issue(MTLO, 32'h55, 32'd0);
    check("MTLO lo", 64'(lo), 64'h55);
    check("MTLO busy", 64'(busy), 64'd0);
    check("MTLO done", 64'(done), 64'd0);
    issue(MTHI, 32'hA5A5, 32'd0);
    check("MTHI hi", 64'(hi), 64'hA5A5);
    check("MTHI busy", 64'(busy), 64'd0);

    // start+cancel together in IDLE: nothing starts.
    start = 1'b1; cancel = 1'b1; op = MULTU; busA = 32'd2; busB = 32'd2;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    check("start+cancel busy", 64'(busy), 64'd0);

    // start while busy is ignored, including MTHI.
    issue(MULTU, 32'd5, 32'd6);
    repeat (3) @(negedge clk);
    start = 1'b1; op = DIVU; busA = 32'd100; busB = 32'd7;
    @(negedge clk);
    op = MTHI; busA = 32'hDEAD;
    @(negedge clk);
    start = 1'b0;
    begin
      int n = 5;
      while (!done && n < 40) begin
        @(negedge clk);
        n++;
      end
      check("busy-start latency", 64'(n), 64'd33);
      check("busy-start hi", 64'(hi), 64'd0);
      check("busy-start lo", 64'(lo), 64'd30);
      $display("busy-start: hi=0x%08h lo=0x%08h edges=%0d", hi, lo, n);
    end
    repeat (3) @(negedge clk);
    check("no second op", 64'(busy), 64'd0);

    // Asynchronous reset mid-divide.
    issue(DIV, 32'd99, 32'd4);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst busy", 64'(busy), 64'd0);
    check("rst hi", 64'(hi), 64'd0);
    check("rst lo", 64'(lo), 64'd0);
    check("rst done", 64'(done), 64'd0);
    $display("reset mid-DIV: busy=%0d hi=0x%08h lo=0x%08h", busy, hi, lo);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post-rst busy", 64'(busy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
